// File: rtl/point_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// point_fetch_ctrl
//
// Walks an inclusive range of RAM addresses and presents one merged point per
// address on a valid/ready stream. Each point is split across two RAM macros
// that share one address: RAM_1 holds the low RAM_W bits, RAM_2 holds the
// remaining DATA_W-RAM_W bits in its low bits. The RAMs have a one-cycle read
// latency, so each point costs one read cycle, one capture cycle and at least
// one presentation cycle.
//
// Parameters
//   ADDR_W  RAM word address width
//   RAM_W   width of one RAM macro word
//   DATA_W  merged point width, RAM_W < DATA_W <= 2*RAM_W
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   go, abort                     start request (idle only), abort of a pass
//   first_addr, last_addr         inclusive address range, sampled at start
//   ram1_q, ram2_q                RAM read data
//   ram_addr                      shared RAM address
//   ram_csb, ram_oeb, ram_web     active-low RAM controls (never writes)
//   point_data, point_valid,
//   point_ready, point_last       output point stream
//   busy, done, range_err         pass status
// ---------------------------------------------------------------------------
module point_fetch_ctrl #(
  parameter int ADDR_W = 9,
  parameter int RAM_W  = 50,
  parameter int DATA_W = 91
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [RAM_W-1:0]  ram1_q,
  input  logic [RAM_W-1:0]  ram2_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_csb,
  output logic              ram_oeb,
  output logic              ram_web,
  output logic [DATA_W-1:0] point_data,
  output logic              point_valid,
  input  logic              point_ready,
  output logic              point_last,
  output logic              busy,
  output logic              done,
  output logic              range_err
);

  localparam int HI_W = DATA_W - RAM_W;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_CAP  = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_end_addr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_csb;
  logic              r_ram_oeb;
  logic              r_ram_web;
  logic [DATA_W-1:0] r_point_data;
  logic              r_point_valid;
  logic              r_point_last;
  logic              r_busy;
  logic              r_done;
  logic              r_range_err;

  logic [2:0]        w_next_state;
  logic [ADDR_W-1:0] w_next_cur;
  logic              w_start;
  logic              w_bad_range;
  logic              w_next_busy;

  assign w_bad_range = (first_addr > last_addr);
  assign w_next_busy = (w_next_state == ST_RD) || (w_next_state == ST_CAP) ||
                       (w_next_state == ST_OUT);

  // RAM_2 bits above the point width carry nothing for this block.
  if (HI_W < RAM_W) begin : g_spare_hi
    logic w_unused_hi;
    assign w_unused_hi = ^ram2_q[RAM_W-1:HI_W];
  end

  // Next-state and next-address decode.
  always_comb begin
    w_next_state = r_state;
    w_next_cur   = r_cur_addr;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_start = 1'b1;
          if (w_bad_range) begin
            w_next_state = ST_FIN;
          end else begin
            w_next_state = ST_RD;
            w_next_cur   = first_addr;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RD: begin
        if (abort) begin
          w_next_state = ST_FIN;
        end else begin
          w_next_state = ST_CAP;
        end
      end
      ST_CAP: begin
        if (abort) begin
          w_next_state = ST_FIN;
        end else begin
          w_next_state = ST_OUT;
        end
      end
      ST_OUT: begin
        // Abort wins over a handshake in the same cycle.
        if (abort) begin
          w_next_state = ST_FIN;
        end else if (r_point_valid && point_ready) begin
          // The last point ends the pass before the address can increment,
          // so the counter never wraps even when last_addr is all ones.
          if (r_point_last) begin
            w_next_state = ST_FIN;
          end else begin
            w_next_state = ST_RD;
            w_next_cur   = r_cur_addr + ADDR_W'(1);
          end
        end else begin
          w_next_state = ST_OUT;
        end
      end
      ST_FIN: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, address counters and registered outputs; outputs are loaded from
  // the next-state decode so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cur_addr    <= '0;
      r_end_addr    <= '0;
      r_ram_addr    <= '0;
      r_ram_csb     <= 1'b1;
      r_ram_oeb     <= 1'b1;
      r_ram_web     <= 1'b1;
      r_point_data  <= '0;
      r_point_valid <= 1'b0;
      r_point_last  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_range_err   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cur_addr <= w_next_cur;
      if (w_start) begin
        r_end_addr  <= last_addr;
        r_range_err <= w_bad_range;
      end
      // ram_addr holds its last value outside reads so it never glitches
      // back to zero between points.
      if (w_next_state == ST_RD) begin
        r_ram_addr <= w_next_cur;
      end
      r_ram_csb <= (w_next_state != ST_RD);
      r_ram_oeb <= (w_next_state != ST_RD);
      r_ram_web <= 1'b1;
      // RAM data requested in RD is on ram*_q during CAP.
      if (r_state == ST_CAP) begin
        r_point_data <= {ram2_q[HI_W-1:0], ram1_q};
      end
      r_point_valid <= (w_next_state == ST_OUT);
      if (w_next_state != ST_OUT) begin
        r_point_last <= 1'b0;
      end else if (r_state == ST_CAP) begin
        r_point_last <= (r_cur_addr == r_end_addr);
      end
      r_busy <= w_next_busy;
      r_done <= (w_next_state == ST_FIN);
    end
  end

  assign ram_addr    = r_ram_addr;
  assign ram_csb     = r_ram_csb;
  assign ram_oeb     = r_ram_oeb;
  assign ram_web     = r_ram_web;
  assign point_data  = r_point_data;
  assign point_valid = r_point_valid;
  assign point_last  = r_point_last;
  assign busy        = r_busy;
  assign done        = r_done;
  assign range_err   = r_range_err;

endmodule
